// File: rtl/scoreboard_pkg.sv
// Shared defaults, FU indices and the result-shift stage entry for the
// parametrised register scoreboard.
package scoreboard_pkg;

    localparam int SB_NUM_REGS = 32;
    localparam int SB_NUM_FU   = 4;
    localparam int SB_MAX_LAT  = 8;
    localparam int SB_LW       = 4;

    localparam int SB_AW = (SB_NUM_REGS > 1) ? $clog2(SB_NUM_REGS) : 1;
    localparam int SB_FW = (SB_NUM_FU > 1) ? $clog2(SB_NUM_FU) : 1;

    // Functional unit indices into the latency vector.
    localparam logic [SB_FW-1:0] FU_ALU = 2'd0;
    localparam logic [SB_FW-1:0] FU_MEM = 2'd1;
    localparam logic [SB_FW-1:0] FU_MUL = 2'd2;
    localparam logic [SB_FW-1:0] FU_DIV = 2'd3;

    // FU k latency sits in bits [k*LW +: LW]: ALU=1, MEM=2, MUL=4, DIV=6.
    localparam logic [SB_NUM_FU*SB_LW-1:0] SB_FU_LAT = {4'd6, 4'd4, 4'd2, 4'd1};

    // One in-flight result. Field widths follow the package register/FU
    // counts; widen them here if a instance uses more registers or FUs.
    typedef struct packed {
        logic             v;
        logic [SB_AW-1:0] rd;
        logic [SB_FW-1:0] fu;
        logic             wen;
    } sb_entry_t;

endpackage

// File: rtl/sb_result_shift.sv
// Result timing shift register: stage 0 is the writeback stage, the top
// stage refills empty, and one stage per cycle may be loaded by issue.
module sb_result_shift
    import scoreboard_pkg::*;
#(
    parameter int  MAX_LAT = SB_MAX_LAT,
    localparam int IW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [IW-1:0]      load_idx_i,
    input  sb_entry_t          load_entry_i,
    output logic [MAX_LAT-1:0] occ_o,
    output sb_entry_t          head_o
);

    sb_entry_t stage_q [MAX_LAT];
    sb_entry_t stage_d [MAX_LAT];

    // Shift every stage down by one and let an accepted issue override its slot.
    always_comb begin
        // NOTE: every stage_d element is assigned before any condition, so no latch is inferred.
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            stage_d[k] = stage_q[k+1];
        end
        stage_d[MAX_LAT-1] = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (load_i && (load_idx_i == IW'(k))) begin
                stage_d[k] = load_entry_i;
            end
        end
    end

    // Stage registers; a reset flushes everything so no stale result writes back.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: these are individual flops rather than a RAM, so all of them are reset.
            for (int k = 0; k < MAX_LAT; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep the whole shift a single simultaneous step.
            for (int k = 0; k < MAX_LAT; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Per-stage occupancy for the write-slot hazard check.
    always_comb begin
        occ_o = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            occ_o[k] = stage_q[k].v;
        end
    end

    assign head_o = stage_q[0];

endmodule

// File: rtl/scoreboard_param.sv
// Parametrised register scoreboard: pending-destination tracking, per-FU
// result latency and a combinational issue permit covering RAW, WAW and
// writeback-slot hazards. Drives the writeback tag stream.
module scoreboard_param
    import scoreboard_pkg::*;
#(
    parameter int                    NUM_REGS = SB_NUM_REGS,
    parameter int                    NUM_FU   = SB_NUM_FU,
    parameter int                    MAX_LAT  = SB_MAX_LAT,
    parameter int                    LW       = SB_LW,
    parameter logic [NUM_FU*LW-1:0]  FU_LAT   = SB_FU_LAT,
    parameter bit                    ZERO_REG = 1'b1,
    localparam int                   AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int                   FW       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int                   IW       = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_wen,
    input  logic [AW-1:0]       issue_rd,
    input  logic [AW-1:0]       issue_rs,
    input  logic [AW-1:0]       issue_rt,
    input  logic [FW-1:0]       issue_fu,
    output logic                issue_ok,
    output logic [NUM_REGS-1:0] pnd_sgn,
    output logic                wb_valid,
    output logic [AW-1:0]       wb_rd,
    output logic [FW-1:0]       wb_fu
);

    logic [NUM_REGS-1:0] pnd_q;
    logic [NUM_REGS-1:0] pnd_d;

    logic [LW-1:0]       lat;
    logic [IW-1:0]       load_idx;
    logic [MAX_LAT-1:0]  occ;
    logic                slot;
    logic                raw;
    logic                waw;
    logic                accept;
    logic                set_en;
    sb_entry_t           load_entry;
    sb_entry_t           head;

    // Latency of the FU the decoder is targeting.
    always_comb begin
        lat = LW'(1);
        for (int k = 0; k < NUM_FU; k++) begin
            if (issue_fu == FW'(k)) begin
                lat = FU_LAT[k*LW +: LW];
            end
        end
    end

    // Load stage is L-1; L = MAX_LAT loads the top stage and never conflicts.
    always_comb begin
        load_idx = '0;
        slot     = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (lat == LW'(k)) begin
                load_idx = IW'(k - 1);
            end
        end
        for (int k = 1; k < MAX_LAT; k++) begin
            if (lat == LW'(k)) begin
                slot = occ[k];
            end
        end
    end

    // Operand and destination hazards against the registered pending set.
    always_comb begin
        raw = (pnd_q[issue_rs] && !(ZERO_REG && (issue_rs == '0))) ||
              (pnd_q[issue_rt] && !(ZERO_REG && (issue_rt == '0)));
        waw = issue_wen && pnd_q[issue_rd];
    end

    assign issue_ok = !raw && !waw && !slot;
    assign accept   = issue_valid && issue_ok && !reset;
    assign set_en   = accept && issue_wen && !(ZERO_REG && (issue_rd == '0));

    always_comb begin
        load_entry     = '0;
        load_entry.v   = 1'b1;
        load_entry.rd  = SB_AW'(issue_rd);
        load_entry.fu  = SB_FW'(issue_fu);
        load_entry.wen = issue_wen;
    end

    sb_result_shift #(
        .MAX_LAT (MAX_LAT)
    ) u_shift (
        .clk_i        (clock),
        .rst_i        (reset),
        .load_i       (accept),
        .load_idx_i   (load_idx),
        .load_entry_i (load_entry),
        .occ_o        (occ),
        .head_o       (head)
    );

    // Writeback tags come straight from the stage-0 flop; zeroed when idle.
    assign wb_valid = head.v && head.wen;
    assign wb_rd    = wb_valid ? AW'(head.rd) : '0;
    assign wb_fu    = wb_valid ? FW'(head.fu) : '0;

    // Pending next state: clear the retiring register, then set the new one (set wins).
    always_comb begin
        pnd_d = pnd_q;
        if (wb_valid) begin
            pnd_d[wb_rd] = 1'b0;
        end
        if (set_en) begin
            pnd_d[issue_rd] = 1'b1;
        end
    end

    // Pending-bit register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pnd_q <= '0;
        end else begin
            pnd_q <= pnd_d;
        end
    end

    assign pnd_sgn = pnd_q;

endmodule

// File: tb/tb_scoreboard_param.sv
// Directed bench for scoreboard_param with default parameters
// (FU latencies ALU=1, MEM=2, MUL=4, DIV=6, MAX_LAT=8, r0 hardwired).
module tb_scoreboard_param;
    import scoreboard_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_wen;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic [1:0]  issue_fu;
    logic        issue_ok;
    logic [31:0] pnd_sgn;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_fu;

    int checks = 0;
    int errors = 0;

    // Expected writeback per window in the slot-conflict scenario.
    logic [31:0] slot_wbv [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd0};
    logic [31:0] slot_rd  [5] = '{32'd0, 32'd0, 32'd10, 32'd11, 32'd0};
    logic [31:0] slot_fu  [5] = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd0};

    scoreboard_param dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_rd    (issue_rd),
        .issue_rs    (issue_rs),
        .issue_rt    (issue_rt),
        .issue_fu    (issue_fu),
        .issue_ok    (issue_ok),
        .pnd_sgn     (pnd_sgn),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_fu       (wb_fu)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int v, input int wen, input int rd, input int rs, input int rt, input int fu);
        issue_valid = 1'(v);
        issue_wen   = 1'(wen);
        issue_rd    = 5'(rd);
        issue_rs    = 5'(rs);
        issue_rt    = 5'(rt);
        issue_fu    = 2'(fu);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // A set and a clear of the same register in one edge must never happen.
    always @(negedge clock) begin
        if (!reset && issue_valid && issue_ok && issue_wen && wb_valid &&
            (issue_rd == wb_rd) && (issue_rd != 5'd0)) begin
            check("set_clr_collide", 32'd1, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset, including an offered issue while reset is high
        reset = 1'b1;
        idle();
        tick();
        drive(1, 1, 5, 5, 5, 0);
        check("ok_in_reset", 32'(issue_ok), 32'd1);
        tick();
        check("rst_pnd", pnd_sgn, 32'd0);
        check("rst_wbv", 32'(wb_valid), 32'd0);
        reset = 1'b0;
        idle();
        tick();
        check("idle_pnd", pnd_sgn, 32'd0);
        check("idle_wbv", 32'(wb_valid), 32'd0);
        check("idle_wbrd", 32'(wb_rd), 32'd0);
        drive(0, 1, 5, 5, 5, 0);
        check("idle_ok", 32'(issue_ok), 32'd1);

        // ---- rd=3 on MEM (L=2): pending after E0, writeback after E1, clear at E2
        drive(1, 1, 3, 1, 2, 1);
        check("mem_ok", 32'(issue_ok), 32'd1);
        tick();
        drive(0, 0, 0, 3, 0, 0);
        check("mem_pnd_e0", pnd_sgn, 32'h8);
        check("mem_wbv_e0", 32'(wb_valid), 32'd0);
        check("mem_raw_e0", 32'(issue_ok), 32'd0);
        tick();
        check("mem_wbv_e1", 32'(wb_valid), 32'd1);
        check("mem_wbrd_e1", 32'(wb_rd), 32'd3);
        check("mem_wbfu_e1", 32'(wb_fu), 32'd1);
        check("mem_pnd_e1", pnd_sgn, 32'h8);
        check("mem_nobypass", 32'(issue_ok), 32'd0);
        tick();
        check("mem_pnd_e2", pnd_sgn, 32'd0);
        check("mem_wbv_e2", 32'(wb_valid), 32'd0);
        check("mem_wbfu_e2", 32'(wb_fu), 32'd0);
        check("mem_ok_e2", 32'(issue_ok), 32'd1);

        // ---- rd=7 on DIV (L=6): RAW/WAW stall through the writeback window
        drive(1, 1, 7, 1, 2, 3);
        check("div_ok", 32'(issue_ok), 32'd1);
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 7, 0, 3);
            check("div_raw", 32'(issue_ok), 32'd0);
            drive(0, 1, 7, 2, 0, 3);
            check("div_waw", 32'(issue_ok), 32'd0);
            drive(0, 0, 7, 2, 0, 3);
            check("div_nowen", 32'(issue_ok), 32'd1);
            drive(0, 1, 8, 2, 0, 3);
            check("div_free", 32'(issue_ok), 32'd1);
            check("div_wbv", 32'(wb_valid), (c == 5) ? 32'd1 : 32'd0);
            check("div_wbrd", 32'(wb_rd), (c == 5) ? 32'd7 : 32'd0);
            tick();
        end
        drive(0, 1, 7, 7, 0, 3);
        check("div_ok_after", 32'(issue_ok), 32'd1);
        check("div_pnd_after", pnd_sgn, 32'd0);

        // ---- slot conflict: DIV at E0, MUL (L=4) blocked at E2, accepted at E3
        drive(1, 1, 10, 1, 1, 3);
        tick();
        idle();
        tick();
        drive(1, 1, 11, 1, 1, 2);
        check("slot_block", 32'(issue_ok), 32'd0);
        tick();
        check("slot_retry_ok", 32'(issue_ok), 32'd1);
        check("slot_pnd_e2", pnd_sgn, 32'h400);
        tick();
        idle();
        check("slot_pnd_e3", pnd_sgn, 32'hC00);
        for (int c = 0; c < 5; c++) begin
            check("slot_wbv", 32'(wb_valid), slot_wbv[c]);
            check("slot_wbrd", 32'(wb_rd), slot_rd[c]);
            check("slot_wbfu", 32'(wb_fu), slot_fu[c]);
            tick();
        end
        check("slot_pnd_end", pnd_sgn, 32'd0);

        // ---- wen=0 entry still owns its slot but never writes back
        drive(1, 0, 12, 1, 1, 3);
        tick();
        idle();
        check("nowen_pnd", pnd_sgn, 32'd0);
        tick();
        drive(0, 1, 13, 1, 1, 2);
        check("nowen_slot", 32'(issue_ok), 32'd0);
        idle();
        for (int c = 0; c < 6; c++) begin
            check("nowen_wbv", 32'(wb_valid), 32'd0);
            tick();
        end

        // ---- write to r0 on MEM: never pending, but the writeback still pulses
        drive(1, 1, 0, 1, 1, 1);
        tick();
        drive(0, 1, 0, 0, 0, 3);
        check("r0_ok", 32'(issue_ok), 32'd1);
        check("r0_pnd_e0", pnd_sgn, 32'd0);
        tick();
        check("r0_wbv", 32'(wb_valid), 32'd1);
        check("r0_wbrd", 32'(wb_rd), 32'd0);
        check("r0_wbfu", 32'(wb_fu), 32'd1);
        check("r0_pnd_e1", pnd_sgn, 32'd0);
        idle();
        tick();
        check("r0_wbv_end", 32'(wb_valid), 32'd0);

        // ---- reset mid-flight discards rd=9 on DIV
        drive(1, 1, 9, 1, 1, 3);
        tick();
        idle();
        check("mid_pnd", pnd_sgn, 32'h200);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_pnd_rst", pnd_sgn, 32'd0);
        for (int c = 0; c < 8; c++) begin
            check("mid_wbv", 32'(wb_valid), 32'd0);
            tick();
        end
        check("mid_pnd_end", pnd_sgn, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
